// File: rtl/interrupt_controller_if.sv
// ---------------------------------------------------------------------------
// interrupt_controller_if
// Bundles the interrupt sources, CSR enables, pipeline qualifiers and the
// request/status outputs of interrupt_controller.
//   master : drives sources, mie/mstatus, pipeline qualifiers, mret;
//            observes irq_out, irq_cause, mip_out, in_service
//   slave  : the controller side (mirror of master)
// ---------------------------------------------------------------------------
interface interrupt_controller_if;
    logic        msip_in;
    logic        mtip_in;
    logic        meip_in;
    logic [31:0] mie_in;
    logic        mstatus_mie;
    logic        mem_inst_valid;
    logic        stall_in;
    logic        exception_in;
    logic        mret_in;
    logic        irq_out;
    logic [3:0]  irq_cause;
    logic [31:0] mip_out;
    logic        in_service;

    modport master (
        output msip_in, mtip_in, meip_in, mie_in, mstatus_mie,
               mem_inst_valid, stall_in, exception_in, mret_in,
        input  irq_out, irq_cause, mip_out, in_service
    );

    modport slave (
        input  msip_in, mtip_in, meip_in, mie_in, mstatus_mie,
               mem_inst_valid, stall_in, exception_in, mret_in,
        output irq_out, irq_cause, mip_out, in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Machine-mode interrupt controller: synchronises the software, timer and
// external interrupt lines, arbitrates them with fixed priority
// MEI(11) > MSI(3) > MTI(7), and hands one request at a time to the
// exception unit when an instruction in MEM can take it.
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : interrupt_controller_if.slave (sources, mie/mstatus, pipeline
//           qualifiers, mret in; irq_out, irq_cause, mip_out, in_service out)
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    interrupt_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    state_t                 r_state;
    logic [3:0]             r_cause;
    logic                   r_in_service;
    logic [SYNC_STAGES-1:0] r_sync_msip;
    logic [SYNC_STAGES-1:0] r_sync_mtip;
    logic [SYNC_STAGES-1:0] r_sync_meip;

    logic       w_mip_msip;
    logic       w_mip_mtip;
    logic       w_mip_meip;
    logic       w_elig_msip;
    logic       w_elig_mtip;
    logic       w_elig_meip;
    logic       w_any_elig;
    logic       w_grant;
    logic [3:0] w_win_cause;
    logic       w_unused_mie;

    // Source synchronisers: shift toward the MSB, the MSB is the pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_msip <= '0;
            r_sync_mtip <= '0;
            r_sync_meip <= '0;
        end else begin
            r_sync_msip <= {r_sync_msip[SYNC_STAGES-2:0], bus.msip_in};
            r_sync_mtip <= {r_sync_mtip[SYNC_STAGES-2:0], bus.mtip_in};
            r_sync_meip <= {r_sync_meip[SYNC_STAGES-2:0], bus.meip_in};
        end
    end

    assign w_mip_msip = r_sync_msip[SYNC_STAGES-1];
    assign w_mip_mtip = r_sync_mtip[SYNC_STAGES-1];
    assign w_mip_meip = r_sync_meip[SYNC_STAGES-1];

    assign w_elig_msip = w_mip_msip & bus.mie_in[3]  & bus.mstatus_mie;
    assign w_elig_mtip = w_mip_mtip & bus.mie_in[7]  & bus.mstatus_mie;
    assign w_elig_meip = w_mip_meip & bus.mie_in[11] & bus.mstatus_mie;
    assign w_any_elig  = w_elig_msip | w_elig_mtip | w_elig_meip;

    // Only bits 3/7/11 of mie matter; the rest are deliberately ignored.
    assign w_unused_mie = ^{bus.mie_in[31:12], bus.mie_in[10:8],
                            bus.mie_in[6:4], bus.mie_in[2:0]};

    always_comb begin
        w_win_cause = 4'd0;
        if (w_elig_meip)
            w_win_cause = CAUSE_MEI;
        else if (w_elig_msip)
            w_win_cause = CAUSE_MSI;
        else if (w_elig_mtip)
            w_win_cause = CAUSE_MTI;
    end

    // A grant needs a real instruction in MEM to attach to; a synchronous
    // exception in the same cycle takes precedence and the request waits.
    assign w_grant = (r_state == PEND) & bus.mem_inst_valid & ~bus.stall_in
                   & ~bus.exception_in & w_any_elig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cause      <= 4'd0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_elig) begin
                        r_state <= PEND;
                        r_cause <= w_win_cause;
                    end
                end
                PEND: begin
                    if (w_grant) begin
                        // Cause stays as presented alongside the pulse.
                        r_state      <= SERVICE;
                        r_in_service <= 1'b1;
                    end else if (!w_any_elig) begin
                        r_state <= IDLE;
                        r_cause <= 4'd0;
                    end else begin
                        r_cause <= w_win_cause;
                    end
                end
                SERVICE: begin
                    // Sources are ignored here; only mret releases the handler.
                    if (bus.mret_in) begin
                        r_state      <= IDLE;
                        r_cause      <= 4'd0;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_cause      <= 4'd0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_out    = w_grant;
    assign bus.irq_cause  = r_cause;
    assign bus.in_service = r_in_service;
    assign bus.mip_out    = {20'd0, w_mip_meip, 3'd0, w_mip_mtip, 3'd0,
                             w_mip_msip, 3'd0};

endmodule
